// File: rtl/lru_data_cache_nway_pkg.sv
// Shared constants, FSM encoding and width helper for the N-way LRU data cache.
package lru_data_cache_nway_pkg;

    localparam logic [2:0] CMD_RD = 3'b001;
    localparam logic [2:0] CMD_WR = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_BUS,
        S_FLUSH
    } state_t;

    // Ceiling log2, used to size the per-way age counters.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/lru_data_cache_nway_age.sv
// Age registers for one set: true-LRU ordering plus victim selection.
module lru_age_set
    import lru_data_cache_nway_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int AGE_W = clog2(WAYS)
) (
    input  logic             clk0,
    input  logic             reset_n,
    input  logic             touch,
    input  logic [AGE_W-1:0] touch_way,
    input  logic [WAYS-1:0]  valid,
    output logic [AGE_W-1:0] victim
);

    logic [WAYS-1:0][AGE_W-1:0] age;
    logic [AGE_W-1:0]           age_t;
    logic                       found;

    assign age_t = age[touch_way];

    // Touched way becomes youngest; only ways younger than it age by one, so the set stays a permutation.
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < WAYS; w++) age[w] <= AGE_W'(w);
        end else if (touch) begin
            for (int w = 0; w < WAYS; w++) begin
                if (AGE_W'(w) == touch_way) age[w] <= '0;
                else if (age[w] < age_t)    age[w] <= age[w] + 1'b1;
            end
        end
    end

    // Prefer the lowest invalid way; otherwise evict the oldest.
    always_comb begin
        victim = '0;
        found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!valid[w] && !found) begin
                victim = AGE_W'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++)
                if (age[w] == AGE_W'(WAYS-1)) victim = AGE_W'(w);
        end
    end

endmodule

// File: rtl/lru_data_cache_nway.sv
// N-way set-associative write-through / no-write-allocate data cache with true LRU.
module lru_data_cache_nway
    import lru_data_cache_nway_pkg::*;
#(
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 32,
    parameter int SET_BITS = 5,
    parameter int WAYS     = 4
) (
    input  logic              clk0,
    input  logic              reset_n,
    input  logic              cache_request,
    input  logic [2:0]        cache_host_cmd,
    input  logic [ADDR_W-1:0] cache_host_addr,
    input  logic [DATA_W-1:0] cache_host_datain,
    input  logic              cache_flush,
    output logic [DATA_W-1:0] cache_host_dataout,
    output logic              cache_ready,
    output logic              cache_done,
    output logic              cache_hit,
    output logic              cache_miss,
    output logic              cache_bus_request,
    input  logic              cache_bus_grant,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [2:0]        cache_cmd,
    output logic [DATA_W-1:0] cache_dataout,
    input  logic [DATA_W-1:0] cache_datain,
    input  logic              cache_bus_ack
);

    localparam int SETS  = 2**SET_BITS;
    localparam int AGE_W = clog2(WAYS);
    localparam int TAG_W = ADDR_W - SET_BITS;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    state_t                    state, state_d;
    req_t                      req;
    logic                      wr_hit;
    logic [SET_BITS-1:0]       fcnt;
    logic [TAG_W-1:0]          tag_mem  [SETS][WAYS];
    logic [DATA_W-1:0]         data_mem [SETS][WAYS];
    logic [SETS-1:0][WAYS-1:0] valid;
    logic [AGE_W-1:0]          victim   [SETS];

    logic [SET_BITS-1:0] idx;
    logic [TAG_W-1:0]    tag;
    logic                hit, grant_on;
    logic [AGE_W-1:0]    hit_way, touch_way, mem_way;
    logic                accept, flush_go, touch, mem_we, fill, done_d, hit_d, miss_d;
    logic [DATA_W-1:0]   dout_d, mem_data;

    assign idx = req.addr[SET_BITS-1:0];
    assign tag = req.addr[ADDR_W-1:SET_BITS];

    // Tag compare across all ways of the latched set; valid lines never share a tag.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[idx][w] && tag_mem[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
    end

    // Next state, array/LRU update strobes and next values of the registered host outputs.
    always_comb begin
        state_d   = state;
        accept    = 1'b0;
        flush_go  = 1'b0;
        touch     = 1'b0;
        touch_way = hit_way;
        mem_we    = 1'b0;
        mem_way   = hit_way;
        mem_data  = req.data;
        fill      = 1'b0;
        done_d    = 1'b0;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        dout_d    = cache_host_dataout;
        case (state)
            S_IDLE: begin
                if (cache_flush) begin
                    flush_go = 1'b1;
                    state_d  = S_FLUSH;
                end else if (cache_request &&
                             (cache_host_cmd == CMD_RD || cache_host_cmd == CMD_WR)) begin
                    accept  = 1'b1;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                touch = hit;
                if (!req.wr) begin
                    if (hit) begin
                        dout_d  = data_mem[idx][hit_way];
                        done_d  = 1'b1;
                        hit_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        miss_d  = 1'b1;
                        state_d = S_BUS;
                    end
                end else begin
                    mem_we  = hit;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                if (cache_bus_grant && cache_bus_ack) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (!req.wr) begin
                        fill      = 1'b1;
                        mem_we    = 1'b1;
                        mem_way   = victim[idx];
                        mem_data  = cache_datain;
                        touch     = 1'b1;
                        touch_way = victim[idx];
                        dout_d    = cache_datain;
                    end else begin
                        hit_d = wr_hit;
                    end
                end
            end
            S_FLUSH: begin
                if (fcnt == SET_BITS'(SETS-1)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, latched request, valid bits and registered host outputs.
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            state              <= S_IDLE;
            req                <= '0;
            wr_hit             <= 1'b0;
            fcnt               <= '0;
            valid              <= '0;
            cache_done         <= 1'b0;
            cache_hit          <= 1'b0;
            cache_miss         <= 1'b0;
            cache_host_dataout <= '0;
        end else begin
            state              <= state_d;
            cache_done         <= done_d;
            cache_hit          <= hit_d;
            cache_miss         <= miss_d;
            cache_host_dataout <= dout_d;
            if (accept)
                req <= '{wr: (cache_host_cmd == CMD_WR), addr: cache_host_addr, data: cache_host_datain};
            if (state == S_LOOKUP) wr_hit <= hit;
            if (flush_go) fcnt <= '0;
            else if (state == S_FLUSH) begin
                fcnt        <= fcnt + 1'b1;
                valid[fcnt] <= '0;
            end
            if (fill) valid[idx][mem_way] <= 1'b1;
        end
    end

    // Tag/data arrays: combinational read, single synchronous write port.
    always_ff @(posedge clk0) begin
        if (mem_we) begin
            tag_mem[idx][mem_way]  <= tag;
            data_mem[idx][mem_way] <= mem_data;
        end
    end

    for (genvar s = 0; s < SETS; s++) begin : g_set
        lru_age_set #(.WAYS(WAYS), .AGE_W(AGE_W)) u_age (
            .clk0      (clk0),
            .reset_n   (reset_n),
            .touch     (touch && idx == SET_BITS'(s)),
            .touch_way (touch_way),
            .valid     (valid[s]),
            .victim    (victim[s])
        );
    end

    // Bus outputs are gated by grant every cycle so nothing leaks while the arbiter looks elsewhere.
    assign cache_ready       = (state == S_IDLE);
    assign cache_bus_request = (state == S_BUS);
    assign grant_on          = cache_bus_request && cache_bus_grant;
    assign cache_addr        = grant_on ? req.addr : '0;
    assign cache_cmd         = grant_on ? (req.wr ? CMD_WR : CMD_RD) : 3'b000;
    assign cache_dataout     = (grant_on && req.wr) ? req.data : '0;

endmodule

// File: tb/tb_lru_data_cache_nway.sv
// Directed bench for lru_data_cache_nway with an expected-result scoreboard.
module tb_lru_data_cache_nway;

    logic        clk0 = 1'b0, reset_n = 1'b0;
    logic        cache_request = 1'b0, cache_flush = 1'b0;
    logic [2:0]  cache_host_cmd = '0;
    logic [23:0] cache_host_addr = '0;
    logic [31:0] cache_host_datain = '0, cache_datain = '0;
    logic        cache_bus_grant = 1'b0, cache_bus_ack = 1'b0;
    logic [31:0] cache_host_dataout, cache_dataout;
    logic        cache_ready, cache_done, cache_hit, cache_miss, cache_bus_request;
    logic [23:0] cache_addr;
    logic [2:0]  cache_cmd;

    int checks = 0, errors = 0;

    typedef struct {
        logic        rd;
        logic [31:0] data;
        logic        hit;
    } exp_t;
    exp_t sb[$];

    lru_data_cache_nway dut (
        .clk0(clk0), .reset_n(reset_n), .cache_request(cache_request),
        .cache_host_cmd(cache_host_cmd), .cache_host_addr(cache_host_addr),
        .cache_host_datain(cache_host_datain), .cache_flush(cache_flush),
        .cache_host_dataout(cache_host_dataout), .cache_ready(cache_ready),
        .cache_done(cache_done), .cache_hit(cache_hit), .cache_miss(cache_miss),
        .cache_bus_request(cache_bus_request), .cache_bus_grant(cache_bus_grant),
        .cache_addr(cache_addr), .cache_cmd(cache_cmd), .cache_dataout(cache_dataout),
        .cache_datain(cache_datain), .cache_bus_ack(cache_bus_ack)
    );

    always #5 clk0 = ~clk0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] cmd, input logic [23:0] addr, input logic [31:0] d);
        int n = 0;
        @(negedge clk0);
        while (!cache_ready && n < 100) begin @(negedge clk0); n++; end
        check("ready_before_req", cache_ready, 1);
        cache_request = 1'b1; cache_host_cmd = cmd; cache_host_addr = addr; cache_host_datain = d;
        @(posedge clk0); #1 cache_request = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        exp_t e;
        cyc = 0;
        do begin @(negedge clk0); cyc++; end while (!cache_done && cyc < 200);
        check("done_seen", cache_done, 1);
        check("sb_depth", sb.size(), 1);
        if (cache_done && sb.size() > 0) begin
            e = sb.pop_front();
            if (e.rd) check("host_dataout", cache_host_dataout, e.data);
            check("hit_flag", cache_hit, e.hit);
        end
        check("busreq_low_at_done", cache_bus_request, 0);
    endtask

    task automatic serve_bus(input logic [2:0] cmd, input logic [23:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int gap, input logic toggle);
        int n = 0;
        while (!cache_bus_request && n < 100) begin @(negedge clk0); n++; end
        check("bus_request", cache_bus_request, 1);
        for (int i = 0; i < gap; i++) begin
            cache_bus_grant = 1'b0; #1;
            check("addr_gated", cache_addr, 0);
            check("cmd_gated", cache_cmd, 0);
            check("busreq_held", cache_bus_request, 1);
            @(negedge clk0);
        end
        if (toggle) begin
            cache_bus_grant = 1'b1; #1;
            check("cmd_on_grant", cache_cmd, cmd);
            @(negedge clk0);
            cache_bus_grant = 1'b0; #1;
            check("addr_regated", cache_addr, 0);
            check("cmd_regated", cache_cmd, 0);
            check("busreq_held_toggle", cache_bus_request, 1);
            @(negedge clk0);
        end
        cache_bus_grant = 1'b1; cache_bus_ack = 1'b1; cache_datain = rdata; #1;
        check("bus_addr", cache_addr, addr);
        check("bus_cmd", cache_cmd, cmd);
        if (cmd == 3'b010) check("bus_wdata", cache_dataout, wdata);
        @(posedge clk0); #1 cache_bus_grant = 1'b0; cache_bus_ack = 1'b0;
    endtask

    task automatic do_read(input logic [23:0] addr, input logic exp_hit, input logic [31:0] data);
        int cyc;
        sb.push_back('{1'b1, data, exp_hit});
        issue(3'b001, addr, 32'h0);
        if (exp_hit) begin
            wait_done(cyc);
            check("hit_latency", cyc, 2);
        end else begin
            @(negedge clk0); @(negedge clk0);
            check("miss_pulse", cache_miss, 1);
            serve_bus(3'b001, addr, 32'h0, data, 0, 1'b0);
            wait_done(cyc);
        end
    endtask

    task automatic do_write(input logic [23:0] addr, input logic [31:0] d, input logic exp_hit,
                            input int gap, input logic toggle);
        int cyc;
        sb.push_back('{1'b0, 32'h0, exp_hit});
        issue(3'b010, addr, d);
        serve_bus(3'b010, addr, d, 32'h0, gap, toggle);
        wait_done(cyc);
    endtask

    task automatic do_flush();
        int low = 0;
        @(negedge clk0);
        cache_flush = 1'b1;
        @(posedge clk0); #1 cache_flush = 1'b0;
        forever begin
            @(negedge clk0);
            if (cache_ready || low >= 100) break;
            low++;
        end
        check("flush_ready_low", low, 32);
        check("flush_done", cache_done, 1);
    endtask

    initial begin
        int nd;
        #12;
        check("rst_ready", cache_ready, 1);
        check("rst_done", cache_done, 0);
        check("rst_busreq", cache_bus_request, 0);
        check("rst_addr", cache_addr, 0);
        check("rst_cmd", cache_cmd, 0);
        check("rst_dataout", cache_dataout, 0);
        check("rst_host_dataout", cache_host_dataout, 0);
        @(negedge clk0) reset_n = 1'b1;

        do_read(24'h000123, 1'b0, 32'hDEADBEEF);
        do_read(24'h000123, 1'b1, 32'hDEADBEEF);
        do_write(24'h000123, 32'h55AA55AA, 1'b1, 5, 1'b1);
        do_read(24'h000123, 1'b1, 32'h55AA55AA);
        do_write(24'h000456, 32'h12345678, 1'b0, 0, 1'b0);
        do_read(24'h000456, 1'b0, 32'h0BADF00D);

        issue(3'b100, 24'h000123, 32'h0);
        nd = 0;
        repeat (5) begin @(negedge clk0); if (cache_done) nd++; end
        check("bad_cmd_no_done", nd, 0);
        check("bad_cmd_ready", cache_ready, 1);

        do_flush();
        do_read(24'h000123, 1'b0, 32'hCAFEF00D);
        do_read(24'h000456, 1'b0, 32'h0BADF00D);

        do_flush();
        for (int t = 1; t <= 4; t++) do_read(24'(t*32 + 3), 1'b0, 32'h1000 + t);
        do_read(24'(1*32 + 3), 1'b1, 32'h1001);
        do_read(24'(5*32 + 3), 1'b0, 32'h1005);
        do_read(24'(1*32 + 3), 1'b1, 32'h1001);
        do_read(24'(2*32 + 3), 1'b0, 32'h2002);

        issue(3'b001, 24'h000777, 32'h0);
        nd = 0;
        while (!cache_bus_request && nd < 100) begin @(negedge clk0); nd++; end
        cache_bus_grant = 1'b1; #1;
        check("pre_reset_addr", cache_addr, 24'h000777);
        #1 reset_n = 1'b0; #1;
        check("arst_ready", cache_ready, 1);
        check("arst_busreq", cache_bus_request, 0);
        check("arst_addr", cache_addr, 0);
        check("arst_cmd", cache_cmd, 0);
        check("arst_miss", cache_miss, 0);
        check("arst_host_dataout", cache_host_dataout, 0);
        @(negedge clk0) cache_bus_grant = 1'b0; reset_n = 1'b1;
        do_read(24'h000123, 1'b0, 32'h31415926);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
